// File: rtl/cs_registers_m_pkg.sv
// Shared CSR definitions: addresses, bit indices, WARL masks, write-op
// encodings, interrupt cause codes and the state bundle used by the decoder.
package cs_registers_m_pkg;

    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIP_MSI_BIT      = 3;
    localparam int MIP_MTI_BIT      = 7;
    localparam int MIP_MEI_BIT      = 11;

    // MPP is hardwired to machine mode, so it always reads as 2'b11
    localparam logic [31:0] MSTATUS_MPP_RO = 32'h0000_1800;
    localparam logic [31:0] MIE_MIP_MASK   = 32'h0000_0888;
    localparam logic [31:0] MISA_VALUE     = 32'h4000_0100;

    localparam logic [31:0] IRQ_CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] IRQ_CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] IRQ_CAUSE_MEI = 32'h8000_000B;

    typedef enum logic [1:0] {
        WR_OP_WRITE = 2'b00,
        WR_OP_SET   = 2'b01,
        WR_OP_CLEAR = 2'b10,
        WR_OP_RSVD  = 2'b11
    } wr_op_e;

    // Snapshot of all readable state, so one decode function serves both ports
    typedef struct packed {
        logic        mstatus_mie;
        logic        mstatus_mpie;
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mscratch;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] mip;
        logic [63:0] mcycle;
        logic [63:0] minstret;
    } csr_state_t;

    function automatic logic [31:0] csr_apply_op(input logic [1:0] op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] operand);
        case (op)
            WR_OP_WRITE: csr_apply_op = operand;
            WR_OP_SET:   csr_apply_op = old_val | operand;
            WR_OP_CLEAR: csr_apply_op = old_val & ~operand;
            default:     csr_apply_op = old_val;
        endcase
    endfunction

endpackage

// File: rtl/cs_registers_m_csr_counter64.sv
// 64-bit counter with increment enable; each 32-bit half can be overwritten,
// and a write to one half leaves the other half with its incremented value.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q, cnt_d;

    // Next value: full 64-bit increment, then per-half write override
    always_comb begin
        cnt_d = cnt_q + {63'b0, inc_i};
        if (wr_lo_i) cnt_d[31:0]  = wdata_i;
        if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end

    // Counter register, frozen while the clock enable is low
    always_ff @(posedge clk_i) begin
        if (reset_i)   cnt_q <= 64'b0;
        else if (en_i) cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cs_registers_m.sv
// Machine-mode CSR file: CSR read/write/set/clear, trap entry and mret,
// mcycle/minstret counters and interrupt qualification.
module cs_registers_m
    import cs_registers_m_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter bit          VECTORED_EN = 1'b1,
    parameter bit          COUNTERS_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clk_en_i,
    input  logic            rd_i,
    input  logic [11:0]     rd_addr_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_illegal_rd_o,
    output logic            rd_illegal_wr_o,
    input  logic            wr_i,
    input  logic [1:0]      wr_op_i,
    input  logic [11:0]     wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            retire_i,
    input  logic            irq_ext_i,
    input  logic            irq_tmr_i,
    input  logic            irq_sw_i,
    output logic            irq_o,
    output logic [XLEN-1:0] irq_cause_o,
    output logic [XLEN-1:0] trap_vector_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [1:0]      hpl_o
);

    logic        mstatus_mie_q, mstatus_mpie_q;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [31:0] rd_data_q;
    logic        rd_illegal_rd_q, rd_illegal_wr_q;
    logic [31:0] mip, pend, wr_old, wr_new;
    logic [63:0] mcycle, minstret;
    logic        wr_legal;
    csr_state_t  st;

    function automatic logic csr_impl(input logic [11:0] a);
        case (a)
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID,
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP:           csr_impl = 1'b1;
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH:   csr_impl = COUNTERS_EN;
            default:                                            csr_impl = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] csr_read(input csr_state_t s, input logic [11:0] a);
        case (a)
            CSR_MHARTID:                csr_read = HART_ID;
            CSR_MSTATUS:                csr_read = MSTATUS_MPP_RO
                                                 | ({31'b0, s.mstatus_mpie} << MSTATUS_MPIE_BIT)
                                                 | ({31'b0, s.mstatus_mie}  << MSTATUS_MIE_BIT);
            CSR_MISA:                   csr_read = MISA_VALUE;
            CSR_MIE:                    csr_read = s.mie;
            CSR_MTVEC:                  csr_read = s.mtvec;
            CSR_MSCRATCH:               csr_read = s.mscratch;
            CSR_MEPC:                   csr_read = s.mepc;
            CSR_MCAUSE:                 csr_read = s.mcause;
            CSR_MTVAL:                  csr_read = s.mtval;
            CSR_MIP:                    csr_read = s.mip;
            CSR_MCYCLE, CSR_CYCLE:      csr_read = s.mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:    csr_read = s.mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:  csr_read = s.minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_read = s.minstret[63:32];
            default:                    csr_read = 32'b0;
        endcase
    endfunction

    assign mip = {20'b0, irq_ext_i, 3'b0, irq_tmr_i, 3'b0, irq_sw_i, 3'b0};

    assign st = '{mstatus_mie: mstatus_mie_q, mstatus_mpie: mstatus_mpie_q,
                  mie: mie_q, mtvec: mtvec_q, mscratch: mscratch_q, mepc: mepc_q,
                  mcause: mcause_q, mtval: mtval_q, mip: mip,
                  mcycle: mcycle, minstret: minstret};

    // Writes to read-only or unimplemented CSRs and the reserved op are dropped
    assign wr_legal = wr_i && csr_impl(wr_addr_i) && (wr_addr_i[11:10] != 2'b11)
                      && (wr_op_i != WR_OP_RSVD);
    assign wr_old   = csr_read(st, wr_addr_i);
    assign wr_new   = csr_apply_op(wr_op_i, wr_old, wr_data_i);

    // CSR state and registered read port; trap beats mret beats CSR write
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= 32'b0;
            mtvec_q         <= MTVEC_RESET;
            mscratch_q      <= 32'b0;
            mepc_q          <= 32'b0;
            mcause_q        <= 32'b0;
            mtval_q         <= 32'b0;
            rd_data_q       <= 32'b0;
            rd_illegal_rd_q <= 1'b0;
            rd_illegal_wr_q <= 1'b0;
        end else if (clk_en_i) begin
            if (rd_i) begin
                rd_data_q       <= csr_read(st, rd_addr_i);
                rd_illegal_rd_q <= !csr_impl(rd_addr_i);
                rd_illegal_wr_q <= !csr_impl(rd_addr_i) || (rd_addr_i[11:10] == 2'b11);
            end
            if (trap_i) begin
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
                mepc_q         <= trap_pc_i & ~32'h3;
                mcause_q       <= trap_cause_i;
                mtval_q        <= trap_tval_i;
            end else begin
                if (mret_i) begin
                    mstatus_mie_q  <= mstatus_mpie_q;
                    mstatus_mpie_q <= 1'b1;
                end else if (wr_legal && wr_addr_i == CSR_MSTATUS) begin
                    mstatus_mie_q  <= wr_new[MSTATUS_MIE_BIT];
                    mstatus_mpie_q <= wr_new[MSTATUS_MPIE_BIT];
                end
                if (wr_legal && wr_addr_i == CSR_MEPC)   mepc_q   <= wr_new & ~32'h3;
                if (wr_legal && wr_addr_i == CSR_MCAUSE) mcause_q <= wr_new;
                if (wr_legal && wr_addr_i == CSR_MTVAL)  mtval_q  <= wr_new;
            end
            if (wr_legal && wr_addr_i == CSR_MIE)      mie_q      <= wr_new & MIE_MIP_MASK;
            if (wr_legal && wr_addr_i == CSR_MSCRATCH) mscratch_q <= wr_new;
            if (wr_legal && wr_addr_i == CSR_MTVEC)
                mtvec_q <= wr_new & (VECTORED_EN ? ~32'h2 : ~32'h3);
        end
    end

    generate
        if (COUNTERS_EN) begin : g_counters
            csr_counter64 u_mcycle (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .en_i    (clk_en_i),
                .inc_i   (1'b1),
                .wr_lo_i (wr_legal && wr_addr_i == CSR_MCYCLE),
                .wr_hi_i (wr_legal && wr_addr_i == CSR_MCYCLEH),
                .wdata_i (wr_new),
                .cnt_o   (mcycle)
            );
            csr_counter64 u_minstret (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .en_i    (clk_en_i),
                .inc_i   (retire_i),
                .wr_lo_i (wr_legal && wr_addr_i == CSR_MINSTRET),
                .wr_hi_i (wr_legal && wr_addr_i == CSR_MINSTRETH),
                .wdata_i (wr_new),
                .cnt_o   (minstret)
            );
        end else begin : g_no_counters
            assign mcycle   = 64'b0;
            assign minstret = 64'b0;
        end
    endgenerate

    // Interrupt qualification with fixed priority MEI > MSI > MTI
    always_comb begin
        pend = mie_q & mip;
        if (pend[MIP_MEI_BIT])      irq_cause_o = IRQ_CAUSE_MEI;
        else if (pend[MIP_MSI_BIT]) irq_cause_o = IRQ_CAUSE_MSI;
        else if (pend[MIP_MTI_BIT]) irq_cause_o = IRQ_CAUSE_MTI;
        else                        irq_cause_o = 32'b0;
    end

    assign irq_o         = mstatus_mie_q && (|pend);
    assign trap_vector_o = {mtvec_q[31:2], 2'b0}
                         + ((mtvec_q[0] && trap_cause_i[31]) ? {25'b0, trap_cause_i[4:0], 2'b0} : 32'b0);
    assign mepc_o          = mepc_q;
    assign hpl_o           = 2'b11;
    assign rd_data_o       = rd_data_q;
    assign rd_illegal_rd_o = rd_illegal_rd_q;
    assign rd_illegal_wr_o = rd_illegal_wr_q;

endmodule

// File: tb/tb_cs_registers_m.sv
// Bench for cs_registers_m: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_cs_registers_m;

    localparam logic [31:0] HART = 32'h0;

    logic        clk = 1'b0;
    logic        reset_i, clk_en_i, rd_i, wr_i, trap_i, mret_i, retire_i;
    logic        irq_ext_i, irq_tmr_i, irq_sw_i;
    logic [11:0] rd_addr_i, wr_addr_i;
    logic [1:0]  wr_op_i;
    logic [31:0] wr_data_i, trap_cause_i, trap_pc_i, trap_tval_i;
    logic [31:0] rd_data_o, irq_cause_o, trap_vector_o, mepc_o;
    logic        rd_illegal_rd_o, rd_illegal_wr_o, irq_o;
    logic [1:0]  hpl_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    cs_registers_m dut (
        .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .rd_i(rd_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .rd_illegal_rd_o(rd_illegal_rd_o), .rd_illegal_wr_o(rd_illegal_wr_o),
        .wr_i(wr_i), .wr_op_i(wr_op_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
        .trap_tval_i(trap_tval_i), .mret_i(mret_i), .retire_i(retire_i),
        .irq_ext_i(irq_ext_i), .irq_tmr_i(irq_tmr_i), .irq_sw_i(irq_sw_i),
        .irq_o(irq_o), .irq_cause_o(irq_cause_o), .trap_vector_o(trap_vector_o),
        .mepc_o(mepc_o), .hpl_o(hpl_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        md_mie, md_mpie;
    logic [31:0] md_mier, md_mtvec, md_mscr, md_mepc, md_mcause, md_mtval;
    logic [63:0] md_cyc, md_ins;
    logic [31:0] e_rd;
    logic        e_ird, e_iwr;

    function automatic logic [31:0] mip_now();
        return (irq_ext_i ? 32'h800 : 32'h0) | (irq_tmr_i ? 32'h80 : 32'h0)
             | (irq_sw_i ? 32'h8 : 32'h0);
    endfunction

    // {implemented, value}
    function automatic logic [32:0] mread(input logic [11:0] a);
        logic [31:0] ms;
        ms = 32'h1800 | (md_mpie ? 32'h80 : 32'h0) | (md_mie ? 32'h8 : 32'h0);
        case (a)
            12'hF11, 12'hF12, 12'hF13: return {1'b1, 32'h0};
            12'hF14:                   return {1'b1, HART};
            12'h300: return {1'b1, ms};
            12'h301: return {1'b1, 32'h4000_0100};
            12'h304: return {1'b1, md_mier};
            12'h305: return {1'b1, md_mtvec};
            12'h340: return {1'b1, md_mscr};
            12'h341: return {1'b1, md_mepc};
            12'h342: return {1'b1, md_mcause};
            12'h343: return {1'b1, md_mtval};
            12'h344: return {1'b1, mip_now()};
            12'hB00, 12'hC00: return {1'b1, md_cyc[31:0]};
            12'hB80, 12'hC80: return {1'b1, md_cyc[63:32]};
            12'hB02, 12'hC02: return {1'b1, md_ins[31:0]};
            12'hB82, 12'hC82: return {1'b1, md_ins[63:32]};
            default: return 33'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [32:0] r, w;
        logic        wl, n_mie, n_mpie;
        logic [31:0] nv, n_mier, n_mtvec, n_mscr, n_mepc, n_mcause, n_mtval;
        logic [63:0] nc, ni;
        if (reset_i) begin
            md_mie = 1'b0; md_mpie = 1'b0; md_mier = 0; md_mtvec = 32'h100;
            md_mscr = 0; md_mepc = 0; md_mcause = 0; md_mtval = 0;
            md_cyc = 0; md_ins = 0; e_rd = 0; e_ird = 1'b0; e_iwr = 1'b0;
        end else if (clk_en_i) begin
            if (rd_i) begin
                r = mread(rd_addr_i);
                e_rd = r[31:0];
                e_ird = !r[32];
                e_iwr = !r[32] || (rd_addr_i[11:10] == 2'b11);
            end
            w  = mread(wr_addr_i);
            wl = wr_i && w[32] && (wr_addr_i[11:10] != 2'b11) && (wr_op_i != 2'b11);
            case (wr_op_i)
                2'b00:   nv = wr_data_i;
                2'b01:   nv = w[31:0] | wr_data_i;
                default: nv = w[31:0] & ~wr_data_i;
            endcase
            n_mie = md_mie; n_mpie = md_mpie; n_mier = md_mier; n_mtvec = md_mtvec;
            n_mscr = md_mscr; n_mepc = md_mepc; n_mcause = md_mcause; n_mtval = md_mtval;
            nc = md_cyc + 64'd1;
            ni = md_ins + 64'(retire_i);
            if (wl) begin
                case (wr_addr_i)
                    12'h300: begin n_mie = nv[3]; n_mpie = nv[7]; end
                    12'h304: n_mier  = nv & 32'h888;
                    12'h305: n_mtvec = nv & ~32'h2;
                    12'h340: n_mscr  = nv;
                    12'h341: n_mepc  = nv & ~32'h3;
                    12'h342: n_mcause = nv;
                    12'h343: n_mtval = nv;
                    12'hB00: nc[31:0]  = nv;
                    12'hB80: nc[63:32] = nv;
                    12'hB02: ni[31:0]  = nv;
                    12'hB82: ni[63:32] = nv;
                    default: ;
                endcase
            end
            // trap and mret overwrite every field they touch, so the later
            // assignment here discards any same-cycle CSR write to that field
            if (trap_i) begin
                n_mepc = trap_pc_i & ~32'h3; n_mcause = trap_cause_i; n_mtval = trap_tval_i;
                n_mpie = md_mie; n_mie = 1'b0;
            end else if (mret_i) begin
                n_mie = md_mpie; n_mpie = 1'b1;
            end
            md_mie = n_mie; md_mpie = n_mpie; md_mier = n_mier; md_mtvec = n_mtvec;
            md_mscr = n_mscr; md_mepc = n_mepc; md_mcause = n_mcause; md_mtval = n_mtval;
            md_cyc = nc; md_ins = ni;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [31:0] pend, ecause, evec;
        if (chk_on) begin
            pend = md_mier & mip_now();
            if (pend[11])     ecause = 32'h8000_000B;
            else if (pend[3]) ecause = 32'h8000_0003;
            else if (pend[7]) ecause = 32'h8000_0007;
            else              ecause = 32'h0;
            evec = md_mtvec & ~32'h3;
            if (md_mtvec[0] && trap_cause_i[31]) evec = evec + 32'd4 * {27'b0, trap_cause_i[4:0]};
            cmp("rd_data", rd_data_o, e_rd);
            cmp("illegal_rd", 32'(rd_illegal_rd_o), 32'(e_ird));
            cmp("illegal_wr", 32'(rd_illegal_wr_o), 32'(e_iwr));
            cmp("irq", 32'(irq_o), 32'(md_mie && (pend != 0)));
            cmp("irq_cause", irq_cause_o, ecause);
            cmp("trap_vector", trap_vector_o, evec);
            cmp("mepc", mepc_o, md_mepc);
            cmp("hpl", 32'(hpl_o), 32'h3);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        rd_i = 0; wr_i = 0; trap_i = 0; mret_i = 0; retire_i = 0;
    endtask

    task automatic do_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        quiet(); wr_i = 1; wr_addr_i = a; wr_op_i = op; wr_data_i = d;
        tick();
        wr_i = 0;
    endtask

    task automatic do_rd(input logic [11:0] a);
        quiet(); rd_i = 1; rd_addr_i = a;
        tick();
        rd_i = 0;
    endtask

    logic [11:0] addr_tbl [0:23] = '{12'hF11, 12'hF14, 12'h300, 12'h301, 12'h304, 12'h305,
                                     12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
                                     12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                                     12'hC82, 12'h7C0, 12'h000, 12'h302, 12'h300, 12'h305};

    initial begin
        reset_i = 1; clk_en_i = 1; quiet();
        rd_addr_i = 0; wr_addr_i = 0; wr_op_i = 0; wr_data_i = 0;
        trap_cause_i = 0; trap_pc_i = 0; trap_tval_i = 0;
        irq_ext_i = 0; irq_tmr_i = 0; irq_sw_i = 0;
        tick(); tick();
        reset_i = 0;
        chk_on = 1'b1;
        cmp("reset rd_data", rd_data_o, 32'h0);

        do_rd(12'h305); cmp("mtvec reset", rd_data_o, 32'h0000_0100);
        do_rd(12'hF14); cmp("mhartid", rd_data_o, HART);
        cmp("mhartid legal", 32'(rd_illegal_rd_o), 32'h0);
        do_rd(12'h7C0); cmp("unimpl data", rd_data_o, 32'h0);
        cmp("unimpl illegal_rd", 32'(rd_illegal_rd_o), 32'h1);

        do_wr(12'h300, 2'b00, 32'hFFFF_FFFF);
        do_rd(12'h300); cmp("mstatus all-ones", rd_data_o, 32'h0000_1888);
        do_wr(12'h300, 2'b10, 32'h8);
        do_rd(12'h300); cmp("mstatus clear MIE", rd_data_o, 32'h0000_1880);
        do_wr(12'hF11, 2'b00, 32'h5);
        do_rd(12'hF11); cmp("ro write data", rd_data_o, 32'h0);
        cmp("ro illegal_wr", 32'(rd_illegal_wr_o), 32'h1);

        do_wr(12'h300, 2'b00, 32'h8);
        quiet(); trap_i = 1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h1236; trap_tval_i = 32'h55;
        tick(); trap_i = 0;
        cmp("trap mepc", mepc_o, 32'h0000_1234);
        do_rd(12'h300); cmp("trap mstatus", rd_data_o, 32'h0000_1880);
        quiet(); mret_i = 1; tick(); mret_i = 0;
        do_rd(12'h300); cmp("mret mstatus", rd_data_o, 32'h0000_1888);

        do_wr(12'h305, 2'b00, 32'h0000_2001);
        trap_cause_i = 32'h8000_000B; #1;
        cmp("vectored target", trap_vector_o, 32'h0000_202C);
        trap_cause_i = 32'h2; #1;
        cmp("exception target", trap_vector_o, 32'h0000_2000);
        trap_cause_i = 0;

        do_wr(12'hB80, 2'b00, 32'h0);
        do_wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
        do_rd(12'hB80); cmp("mcycleh before carry", rd_data_o, 32'h0);
        do_rd(12'hB80); cmp("mcycleh after carry", rd_data_o, 32'h1);
        do_rd(12'hB00); cmp("mcycle low after carry", rd_data_o, 32'h1);

        do_wr(12'hB82, 2'b00, 32'h0);
        do_wr(12'hB02, 2'b00, 32'h0);
        quiet(); retire_i = 1; tick(); tick(); tick();
        do_rd(12'hB02); cmp("minstret +3", rd_data_o, 32'h3);
        quiet(); retire_i = 1; wr_i = 1; wr_addr_i = 12'hB02; wr_op_i = 2'b00; wr_data_i = 32'h100;
        tick();
        do_rd(12'hB02); cmp("minstret write wins", rd_data_o, 32'h100);

        do_wr(12'h304, 2'b00, 32'h888);
        do_wr(12'h300, 2'b01, 32'h8);
        irq_tmr_i = 1; irq_ext_i = 1; #1;
        cmp("irq asserted", 32'(irq_o), 32'h1);
        cmp("irq cause MEI", irq_cause_o, 32'h8000_000B);
        do_wr(12'h300, 2'b10, 32'h8);
        cmp("irq masked", 32'(irq_o), 32'h0);
        irq_tmr_i = 0; irq_ext_i = 0;

        // Randomized traffic; the negedge compare process checks every cycle
        for (int i = 0; i < 4000; i++) begin
            reset_i   = ($urandom_range(299) == 0);
            clk_en_i  = ($urandom_range(7) != 0);
            rd_i      = ($urandom_range(1) == 0);
            rd_addr_i = ($urandom_range(4) == 0) ? 12'($urandom) : addr_tbl[$urandom_range(23)];
            wr_i      = ($urandom_range(2) == 0);
            wr_addr_i = ($urandom_range(4) == 0) ? 12'($urandom) : addr_tbl[$urandom_range(23)];
            wr_op_i   = 2'($urandom_range(3));
            wr_data_i = ($urandom_range(5) == 0) ? 32'hFFFF_FFFF : $urandom;
            trap_i    = ($urandom_range(11) == 0);
            mret_i    = ($urandom_range(11) == 0);
            retire_i  = ($urandom_range(1) == 0);
            trap_cause_i = {1'($urandom_range(1)), 26'($urandom), 5'($urandom)};
            trap_pc_i    = $urandom;
            trap_tval_i  = $urandom;
            if ($urandom_range(7) == 0) begin
                irq_ext_i = ($urandom_range(1) == 0);
                irq_tmr_i = ($urandom_range(1) == 0);
                irq_sw_i  = ($urandom_range(1) == 0);
            end
            tick();
        end

        quiet(); reset_i = 0;
        tick(); tick();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cs_registers_m.md
Name: cs_registers_m

Overview:
- Parametrised machine-mode CSR file for the RV32I core; successor to the ID-only CSR block.
- Implements read/write/set/clear CSR access, the trap-entry and mret state updates, the mcycle and minstret counters, and interrupt-pending qualification.
- Sits beside the execute stage: CSR instructions read/write it, and the trap controller drives trap/mret strobes and consumes the vector, mepc and irq outputs.

Parameters:
- XLEN, 32, register width; only 32 is supported.
- HART_ID, 0, value returned by mhartid (0xF14).
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec (BASE field, MODE=0).
- VECTORED_EN, 1, 1 allows mtvec.MODE=1 (vectored); 0 forces MODE to 0 (WARL).
- COUNTERS_EN, 1, 1 implements mcycle/minstret(h); 0 reads them as 0 and flags illegal_rd.

Ports:
- clk_i in 1: clock.
- reset_i in 1: synchronous, active-high reset.
- clk_en_i in 1: global clock enable; no state changes when low.
- rd_i in 1: capture the read result.
- rd_addr_i in 12: read/query address.
- rd_data_o out XLEN: registered read data.
- rd_illegal_rd_o out 1: registered; the address is not implemented.
- rd_illegal_wr_o out 1: registered; the address is read-only (addr[11:10]==2'b11) or not implemented.
- wr_i in 1: write strobe; ignored when the address is illegal for write.
- wr_op_i in 2: 00 write, 01 set (OR), 10 clear (AND-NOT), 11 reserved (treated as no write).
- wr_addr_i in 12: write address.
- wr_data_i in XLEN: write operand.
- trap_i in 1: trap-entry strobe.
- trap_cause_i in XLEN: mcause value; bit31 = interrupt.
- trap_pc_i in XLEN: faulting/interrupted PC.
- trap_tval_i in XLEN: mtval value.
- mret_i in 1: mret strobe.
- retire_i in 1: one instruction retired this cycle.
- irq_ext_i, irq_tmr_i, irq_sw_i in 1 each: level interrupt lines (MEIP, MTIP, MSIP).
- irq_o out 1: an interrupt is enabled and pending.
- irq_cause_o out XLEN: cause of the highest-priority pending interrupt.
- trap_vector_o out XLEN: target PC for the current trap_cause_i.
- mepc_o out XLEN: current mepc.
- hpl_o out 2: privilege level; constant 2'b11.

Behaviour:
- All state updates occur only when clk_en_i=1.
- Reset (reset_i high at a clock edge, regardless of clk_en_i):
  - mstatus.MIE=0, MPIE=0; MPP reads 2'b11 constantly.
  - mie, mepc, mcause, mtval, mscratch = 0; mtvec = MTVEC_RESET.
  - mcycle = 0, minstret = 0.
  - rd_data_o, rd_illegal_rd_o, rd_illegal_wr_o = 0.
- Implemented addresses:
  - F11–F14: vendor/arch/impl IDs, mhartid.
  - 300 mstatus; 301 misa (read-only, 0x40000100); 304 mie; 305 mtvec; 340 mscratch; 341 mepc; 342 mcause; 343 mtval; 344 mip.
  - B00/B80 mcycle/h; B02/B82 minstret/h; C00/C80/C02/C82 read-only shadows of the counters.
- Reads:
  - rd_data_o is the combinational decode registered when rd_i=1; one-cycle latency.
  - rd_data_o holds its value when rd_i=0.
  - Unimplemented addresses read 0.
- Writes:
  - new = write: wdata; set: old|wdata; clear: old&~wdata.
  - WARL masks applied after the op:
    - mstatus keeps only bits 3 and 7.
    - mie and mip keep only bits 3, 7, 11.
    - mtvec[1]=0; mtvec[0]=0 when VECTORED_EN=0.
    - mepc[1:0]=0.
  - mip is read-only (MEIP/MTIP/MSIP mirror the inputs); writes to it are ignored.
- Trap entry (trap_i):
  - mepc <= trap_pc_i & ~3; mcause <= trap_cause_i; mtval <= trap_tval_i.
  - MPIE <= MIE; MIE <= 0.
- mret (mret_i): MIE <= MPIE; MPIE <= 1.
- Priority: trap_i > mret_i > wr_i. A lower-priority update on the same field in the same cycle is dropped entirely.
- Counters:
  - mcycle += 1 every enabled cycle; minstret += 1 when retire_i.
  - Both are 64-bit and wrap from 2^64-1 to 0; the carry crosses the low/high halves within the same cycle.
  - A CSR write to either half takes precedence over that cycle's increment, and the other half keeps its incremented value.
- trap_vector_o (combinational):
  - mtvec.MODE=1 and trap_cause_i[31]=1: {mtvec[31:2],2'b0} + 4*trap_cause_i[4:0].
  - Otherwise: {mtvec[31:2],2'b0}.
- Interrupts:
  - irq_o = MIE & |(mie & mip), combinational.
  - Priority MEI(11) > MSI(3) > MTI(7); irq_cause_o = 0x8000_0000 | code.
  - irq_cause_o = 0 when nothing is pending.

Decomposition:
- Shared package/defs file (the existing riscv_defs include): CSR address constants, mstatus/mip bit indices, WARL masks, wr_op encodings, interrupt cause codes.
- One natural sub-module: csr_counter64 — 64-bit counter with increment enable and per-half write; instantiated for mcycle and minstret.

Test Plan:
- Reset, then read 0x305 -> rd_data_o=0x0000_0100 one cycle after rd_i; read 0xF14 -> HART_ID; read 0x7C0 -> data 0, illegal_rd=1.
- Write 0x300=0xFFFF_FFFF, then read -> 0x0000_1888 (MIE|MPIE|MPP); clear 0x8 -> 0x0000_1880; write 0xF11 -> illegal_wr=1 and no state change.
- MIE=1, trap_i with cause 0x8000_0007, pc 0x0000_1236 -> mepc=0x1234, MIE=0, MPIE=1; then mret_i -> MIE=1, MPIE=1.
- mtvec=0x0000_2001, trap_cause_i=0x8000_000B -> trap_vector_o=0x0000_202C; with cause 0x2 -> 0x0000_2000.
- Write mcycle low=0xFFFF_FFFF, high=0 -> next cycle mcycle reads 0x1_0000_0000; retire_i held for 3 cycles -> minstret +3; write minstret concurrent with retire_i -> the written value wins.
- MIE=1, mie=0x888, irq_tmr_i=1 and irq_ext_i=1 together -> irq_o=1, irq_cause_o=0x8000_000B; clear MIE -> irq_o=0.
